// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator: decode at stage 0, valid/ready register stages,
// synchronous flush and a saturating illegal-result counter. Optional macro: IMM_GEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  // Every format fits in 32 bits; one sign extension to XLEN covers RV64 too.
  // zimm has a zero bit 31, so the same extension zero-extends it.
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_ILL;
    case (in_instr[6:0])
      7'b0110011: dec_fmt = FMT_R;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
        if (in_instr[14:12] != 3'b000) begin
          dec_fmt = FMT_Z;
          imm32   = {27'b0, in_instr[19:15]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
`else
        dec_fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
      end
      7'b0111011: begin
        if (XLEN == 64) dec_fmt = FMT_R;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      default: ;
    endcase
    dec_ill = (dec_fmt == FMT_ILL);
    dec_imm = XLEN'($signed(imm32));
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] ill_q;
  logic [XLEN-1:0]   imm_q [STAGES];
  logic [2:0]        fmt_q [STAGES];
  logic              ld_acc;

  // A stage loads if it or any stage downstream is empty, or the consumer takes the head.
  always_comb begin
    ld     = '0;
    ld_acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld_acc = ld_acc | ~vld[k];
      ld[k]  = ld_acc;
    end
  end

  assign in_ready = flush | ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      ill_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        imm_q[k] <= '0;
        fmt_q[k] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (ld[0]) begin
        vld[0]   <= in_valid;
        imm_q[0] <= dec_imm;
        fmt_q[0] <= dec_fmt;
        ill_q[0] <= dec_ill;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          vld[k]   <= vld[k-1];
          imm_q[k] <= imm_q[k-1];
          fmt_q[k] <= fmt_q[k-1];
          ill_q[k] <= ill_q[k-1];
        end
      end
    end
  end

  assign out_valid   = vld[STAGES-1];
  assign out_imm     = imm_q[STAGES-1];
  assign out_fmt     = fmt_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];

  // Counts delivered illegal results, including one handed over during a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (out_valid && out_ready && out_illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe: two instances (RV32/1 stage/3-bit counter and
// RV64/2 stages/16-bit counter) checked every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_instr [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [63:0] out_imm [2];
  logic [2:0]  out_fmt [2];
  logic        out_illegal [2];
  logic [15:0] illegal_cnt [2];

  logic [31:0] imm0;
  logic [2:0]  cnt0;
  logic [63:0] imm1;
  logic [15:0] cnt1;

  int tests = 0;
  int fails = 0;
  logic fired_in [2] = '{1'b0, 1'b0};
  int cyc [2] = '{0, 0};
  exp_t sb [2][16];
  int hd [2] = '{0, 0};
  int tl [2] = '{0, 0};
  int cnt_m [2] = '{0, 0};
  logic [31:0] dq0 [$];
  logic [31:0] dq1 [$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .CNT_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_instr(in_instr[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_imm(imm0), .out_fmt(out_fmt[0]), .out_illegal(out_illegal[0]),
    .illegal_cnt(cnt0)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_instr(in_instr[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_imm(imm1), .out_fmt(out_fmt[1]), .out_illegal(out_illegal[1]),
    .illegal_cnt(cnt1)
  );

  assign out_imm[0]     = {32'b0, imm0};
  assign illegal_cnt[0] = {13'b0, cnt0};
  assign out_imm[1]     = imm1;
  assign illegal_cnt[1] = cnt1;

  function automatic int stg_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 0) ? 7 : 65535;
  endfunction

  // Reference decode straight from the opcode table; RV32 results are zero-extended
  // to 64 bits to match how the RV32 instance is observed.
  function automatic exp_t ref_dec(input logic [31:0] x, input bit is64);
    exp_t        e;
    logic [31:0] v;
    logic        s;
    s     = x[31];
    v     = 32'd0;
    e.fmt = 3'd7;
    e.t   = 0;
    case (x[6:0])
      7'h33: e.fmt = 3'd0;
      7'h03, 7'h13, 7'h67, 7'h0F: begin e.fmt = 3'd1; v = {{20{s}}, x[31:20]}; end
      7'h23: begin e.fmt = 3'd2; v = {{20{s}}, x[31:25], x[11:7]}; end
      7'h63: begin e.fmt = 3'd3; v = {{19{s}}, s, x[7], x[30:25], x[11:8], 1'b0}; end
      7'h37, 7'h17: begin e.fmt = 3'd4; v = {x[31:12], 12'h000}; end
      7'h6F: begin e.fmt = 3'd5; v = {{11{s}}, s, x[19:12], x[20], x[30:21], 1'b0}; end
      7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
        if (x[14:12] != 3'b000) begin e.fmt = 3'd6; v = {27'd0, x[19:15]}; end
        else begin e.fmt = 3'd1; v = {{20{s}}, x[31:20]}; end
`else
        e.fmt = 3'd1; v = {{20{s}}, x[31:20]};
`endif
      end
      7'h3B: if (is64) e.fmt = 3'd0;
      7'h1B: if (is64) begin e.fmt = 3'd1; v = {{20{s}}, x[31:20]}; end
      default: ;
    endcase
    e.ill = (e.fmt == 3'd7);
    e.imm = is64 ? {{32{v[31]}}, v} : {32'd0, v};
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops [14] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h73, 7'h3B, 7'h1B, 7'h00};
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 16);
    if (k < 14) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor + model, sampled on the falling edge; the model step predicts the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy, exp_ov;
    int   sz;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_out_valid[%0d]", i), {63'd0, out_valid[i]}, 64'd0);
        chk($sformatf("rst_cnt[%0d]", i), {48'd0, illegal_cnt[i]}, 64'd0);
        hd[i] = 0; tl[i] = 0; cnt_m[i] = 0; fired_in[i] = 1'b0;
      end else begin
        cyc[i]++;
        sz      = tl[i] - hd[i];
        exp_rdy = flush[i] || out_ready[i] || (sz < stg_of(i));
        exp_ov  = (sz > 0) && ((cyc[i] - sb[i][hd[i] % 16].t) >= stg_of(i));
        chk($sformatf("in_ready[%0d]", i), {63'd0, in_ready[i]}, {63'd0, exp_rdy});
        chk($sformatf("out_valid[%0d]", i), {63'd0, out_valid[i]}, {63'd0, exp_ov});
        if (exp_ov && out_valid[i]) begin
          e = sb[i][hd[i] % 16];
          chk($sformatf("out_imm[%0d]", i), out_imm[i], e.imm);
          chk($sformatf("out_fmt[%0d]", i), {61'd0, out_fmt[i]}, {61'd0, e.fmt});
          chk($sformatf("out_illegal[%0d]", i), {63'd0, out_illegal[i]}, {63'd0, e.ill});
        end
        chk($sformatf("illegal_cnt[%0d]", i), {48'd0, illegal_cnt[i]}, 64'(cnt_m[i]));
        fired_in[i] = in_valid[i] && in_ready[i] && !flush[i];
        if (exp_ov && out_ready[i]) begin
          e = sb[i][hd[i] % 16];
          hd[i]++;
          if (e.ill && cnt_m[i] < cmax_of(i)) cnt_m[i]++;
        end
        if (flush[i]) begin
          tl[i] = hd[i];
        end else if (in_valid[i] && exp_rdy) begin
          e   = ref_dec(in_instr[i], i == 1);
          e.t = cyc[i];
          sb[i][tl[i] % 16] = e;
          tl[i]++;
        end
      end
    end
  end

  task automatic step(input int i, input logic v, input logic [31:0] x,
                      input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid[i]  = v;
    in_instr[i]  = x;
    out_ready[i] = r;
    flush[i]     = f;
  endtask

  task automatic drive(input int i, input int ncyc, input int pv, input int pr, input int pf);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (!in_valid[i] || fired_in[i]) begin
        if (i == 0 && dq0.size() > 0) begin
          in_valid[i] = 1'b1; in_instr[i] = dq0.pop_front();
        end else if (i == 1 && dq1.size() > 0) begin
          in_valid[i] = 1'b1; in_instr[i] = dq1.pop_front();
        end else begin
          in_valid[i] = ($urandom_range(0, 99) < pv);
          in_instr[i] = rnd_instr();
        end
      end
      out_ready[i] = ($urandom_range(0, 99) < pr);
      flush[i]     = ($urandom_range(0, 99) < pf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t p;
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0; in_valid[i] = 1'b0; in_instr[i] = 32'd0; out_ready[i] = 1'b0;
    end

    // Hand-computed values pinning the reference decode
    p = ref_dec(32'hFFF00093, 1'b0);
    chk("pin_addi_imm", p.imm, 64'h0000_0000_FFFF_FFFF);
    chk("pin_addi_fmt", 64'(p.fmt), 64'd1);
    p = ref_dec(32'hFE112E23, 1'b0);
    chk("pin_sw_imm", p.imm, 64'h0000_0000_FFFF_FFFC);
    chk("pin_sw_fmt", 64'(p.fmt), 64'd2);
    p = ref_dec(32'h123450B7, 1'b0);
    chk("pin_lui_imm", p.imm, 64'h0000_0000_1234_5000);
    p = ref_dec(32'h001000EF, 1'b0);
    chk("pin_jal_imm", p.imm, 64'h0000_0000_0000_0800);
    chk("pin_jal_fmt", 64'(p.fmt), 64'd5);
    p = ref_dec(32'h00000000, 1'b0);
    chk("pin_ill", {60'd0, p.fmt, p.ill}, {60'd0, 3'd7, 1'b1});
    p = ref_dec(32'h8000003B, 1'b1);
    chk("pin_addw_fmt", 64'(p.fmt), 64'd0);
    p = ref_dec(32'h8000003B, 1'b0);
    chk("pin_addw_rv32", 64'(p.fmt), 64'd7);
    p = ref_dec(32'hFFF0009B, 1'b1);
    chk("pin_addiw_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    p = ref_dec(32'h300FD073, 1'b1);
`ifdef IMM_GEN_ZICSR_EN
    chk("pin_csrwi", {p.imm[60:0], p.fmt}, {61'h1F, 3'd6});
`else
    chk("pin_csrwi", {p.imm[60:0], p.fmt}, {61'h300, 3'd1});
`endif

    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("por_imm[%0d]", i), out_imm[i], 64'd0);
      chk($sformatf("por_fmt[%0d]", i), 64'(out_fmt[i]), 64'd0);
      chk($sformatf("por_ill[%0d]", i), 64'(out_illegal[i]), 64'd0);
    end
    #11 rst_n = 1'b1;

    // addi through a single stage: result one cycle later
    step(0, 1'b1, 32'hFFF00093, 1'b1, 1'b0);
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("addi_valid", 64'(out_valid[0]), 64'd1);
    chk("addi_imm", out_imm[0], 64'h0000_0000_FFFF_FFFF);

    dq0 = '{32'hFE112E23, 32'h123450B7, 32'h001000EF};
    drive(0, 6, 0, 100, 0);

    // Backpressure: four sent into two stages while the consumer stalls
    dq1 = '{32'hFFF00093, 32'hFE112E23, 32'h123450B7, 32'h001000EF};
    drive(1, 3, 0, 0, 0);
    drive(1, 8, 0, 100, 0);

    // Illegal followed by a flush of two in-flight entries
    step(1, 1'b1, 32'h00000000, 1'b1, 1'b0);
    step(1, 1'b1, 32'h00000013, 1'b1, 1'b0);
    step(1, 1'b1, 32'h00500093, 1'b1, 1'b0);
    step(1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(1, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_cnt", 64'(illegal_cnt[1]), 64'd1);
    chk("flush_empty", 64'(out_valid[1]), 64'd0);

    dq1 = '{32'h8000003B, 32'hFFF0009B, 32'h300FD073, 32'h0000003B};
    drive(1, 8, 0, 100, 0);

    // Counter saturation on the 3-bit instance
    for (int k = 0; k < 10; k++) dq0.push_back(32'h00000000);
    drive(0, 16, 0, 100, 0);
    @(negedge clk);
    chk("sat_cnt", 64'(illegal_cnt[0]), 64'd7);

    fork
      drive(0, 3000, 70, 70, 3);
      drive(1, 3000, 75, 55, 3);
      begin
        repeat (1500) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("async_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
          chk($sformatf("async_imm[%0d]", i), out_imm[i], 64'd0);
          chk($sformatf("async_cnt[%0d]", i), 64'(illegal_cnt[i]), 64'd0);
        end
        #9 rst_n = 1'b1;
      end
    join

    fork
      drive(0, 10, 0, 100, 0);
      drive(1, 10, 0, 100, 0);
    join
    @(negedge clk);
    #1;
    chk("drain0", 64'(tl[0] - hd[0]), 64'd0);
    chk("drain1", 64'(tl[1] - hd[1]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
